conv3x3_stream_layer: RTL and testbench

Parametrised single-channel 3x3 convolution layer for the CNN datapath. It accepts a raster-order IMG_SIZE×IMG_SIZE pixel stream and generates the zero-padding border internally. It keeps a two-row line buffer and a 3x3 window, and runs a pipelined 9-tap MAC with bias and optional ReLU. It replaces the fixed-size pad/line-buffer/PE chains with one configurable block that also reports output coordinates, frame completion and busy status.

---
 rtl/conv3x3_stream_layer.sv | 122 ++++++++++++
 tb/tb_conv3x3_stream_layer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_layer.sv
// conv3x3_stream_layer: streaming single-channel 3x3 convolution with internal zero padding,
// two-row line buffer, pipelined 9-tap MAC, bias and optional ReLU.
// Ports: clk/reset (async, active-high); pixel_in/valid_in/ready input stream;
// weight_load/weight/bias kernel capture (only while idle); pixel_out/valid_out/out_row/out_col
// result stream; frame_done pulse on the last output; busy from first sample until frame_done.
module conv3x3_stream_layer #(
    parameter int IMG_SIZE = 14,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 48,
    parameter int PAD_EN   = 1,
    parameter int RELU_EN  = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [DATA_W-1:0]        pixel_in,
    input  logic                            valid_in,
    output logic                            ready,
    input  logic                            weight_load,
    input  logic [9*DATA_W-1:0]             weight,
    input  logic signed [DATA_W-1:0]        bias,
    output logic signed [ACC_W-1:0]         pixel_out,
    output logic                            valid_out,
    output logic [$clog2(IMG_SIZE)-1:0]     out_row,
    output logic [$clog2(IMG_SIZE)-1:0]     out_col,
    output logic                            frame_done,
    output logic                            busy
);
    localparam int P  = IMG_SIZE + 2 * PAD_EN;
    localparam int CW = $clog2(P);
    localparam int OW = $clog2(IMG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(P - 1);
    localparam logic [CW-1:0] TWO  = CW'(2);

    logic [CW-1:0]              pr, pc;
    logic                       border, produce, win_v, win_last, p_v, p_last;
    logic [OW-1:0]              win_r, win_c, p_r, p_c;
    logic signed [DATA_W-1:0]   sample, bias_r;
    logic signed [DATA_W-1:0]   w_r [9];
    logic signed [DATA_W-1:0]   win [9];
    logic signed [DATA_W-1:0]   lb0 [P];
    logic signed [DATA_W-1:0]   lb1 [P];
    logic signed [2*DATA_W-1:0] prod [9];
    logic signed [ACC_W-1:0]    sum, res;

    assign border  = (PAD_EN != 0) && (pr == '0 || pc == '0 || pr == LAST || pc == LAST);
    assign ready   = !reset && !border;
    assign produce = border || (valid_in && ready);
    assign sample  = border ? '0 : pixel_in;

    always_comb begin
        sum = ACC_W'(bias_r);
        for (int i = 0; i < 9; i++) sum = sum + ACC_W'(prod[i]);
        res = (RELU_EN != 0 && sum[ACC_W-1]) ? '0 : sum;
    end

    // Line buffers are indexed by column: lb0[pc] holds the previous row, lb1[pc] the one before.
    // Data registers carry no reset; the counter-derived valids decide what is meaningful.
    always_ff @(posedge clk) begin
        if (produce) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]   <= win[3*r+1];
                win[3*r+1] <= win[3*r+2];
            end
            win[2]  <= lb1[pc];
            win[5]  <= lb0[pc];
            win[8]  <= sample;
            lb1[pc] <= lb0[pc];
            lb0[pc] <= sample;
        end
        for (int i = 0; i < 9; i++) prod[i] <= (2*DATA_W)'(win[i]) * (2*DATA_W)'(w_r[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr         <= '0;
            pc         <= '0;
            win_v      <= 1'b0;
            win_last   <= 1'b0;
            win_r      <= '0;
            win_c      <= '0;
            p_v        <= 1'b0;
            p_last     <= 1'b0;
            p_r        <= '0;
            p_c        <= '0;
            pixel_out  <= '0;
            valid_out  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            bias_r     <= '0;
            for (int i = 0; i < 9; i++) w_r[i] <= '0;
        end else begin
            if (produce) begin
                pc <= (pc == LAST) ? '0 : pc + 1'b1;
                if (pc == LAST) pr <= (pr == LAST) ? '0 : pr + 1'b1;
            end
            win_v      <= produce && pr >= TWO && pc >= TWO;
            win_last   <= pr == LAST && pc == LAST;
            win_r      <= OW'(pr - TWO);
            win_c      <= OW'(pc - TWO);
            p_v        <= win_v;
            p_last     <= win_last;
            p_r        <= win_r;
            p_c        <= win_c;
            valid_out  <= p_v;
            frame_done <= p_v && p_last;
            if (p_v) begin
                pixel_out <= res;
                out_row   <= p_r;
                out_col   <= p_c;
            end
            // The final output of a frame clears busy even if the next frame has already begun
            // feeding samples; the next produced sample raises it again.
            busy <= (p_v && p_last) ? 1'b0 : (busy || produce);
            if (weight_load && !busy) begin
                for (int i = 0; i < 9; i++) w_r[i] <= weight[i*DATA_W +: DATA_W];
                bias_r <= bias;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_layer.sv
// tb_conv3x3_stream_layer: scoreboard bench for two 4x4 instances (padded, and valid-conv with ReLU).
module tb_conv3x3_stream_layer;
    typedef struct {
        longint v;
        int     r;
        int     c;
        bit     last;
    } exp_t;

    logic               clk = 0, reset_a = 1, reset_b = 1;
    logic signed [15:0] pixel_in = '0, bias = '0;
    logic               valid_in = 0, weight_load = 0;
    logic [143:0]       weight = '0;
    logic               ready_a, valid_a, fd_a, busy_a, ready_b, valid_b, fd_b, busy_b;
    logic signed [47:0] pix_a, pix_b;
    logic [1:0]         row_a, col_a, row_b, col_b;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   total = 0, bad = 0, cyc = 0, first_a = -1, hs5 = 0, rb_low = 0, lc = 0, g = 0;
    bit   b_active = 0;
    int   ones_t[16] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};
    int   b_t[4] = '{45, 54, 81, 90};
    logic [143:0] ident;

    conv3x3_stream_layer #(.IMG_SIZE(4), .DATA_W(16), .ACC_W(48), .PAD_EN(1), .RELU_EN(0)) dut_a (
        .clk(clk), .reset(reset_a), .pixel_in(pixel_in), .valid_in(valid_in), .ready(ready_a),
        .weight_load(weight_load), .weight(weight), .bias(bias), .pixel_out(pix_a),
        .valid_out(valid_a), .out_row(row_a), .out_col(col_a), .frame_done(fd_a), .busy(busy_a));

    conv3x3_stream_layer #(.IMG_SIZE(4), .DATA_W(16), .ACC_W(48), .PAD_EN(0), .RELU_EN(1)) dut_b (
        .clk(clk), .reset(reset_b), .pixel_in(pixel_in), .valid_in(valid_in), .ready(ready_b),
        .weight_load(weight_load), .weight(weight), .bias(bias), .pixel_out(pix_b),
        .valid_out(valid_b), .out_row(row_b), .out_col(col_b), .frame_done(fd_b), .busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_a && valid_a) begin
            if (first_a < 0) first_a = cyc;
            if (qa.size() == 0) check("a_extra_output", 1, 0);
            else begin
                ea = qa.pop_front();
                check("a_pixel_out", longint'(pix_a), ea.v);
                check("a_out_row", row_a, ea.r);
                check("a_out_col", col_a, ea.c);
                check("a_frame_done", fd_a, ea.last);
            end
        end
    end

    always @(negedge clk) begin
        if (b_active && !ready_b) rb_low++;
        if (!reset_b && valid_b) begin
            if (qb.size() == 0) check("b_extra_output", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_pixel_out", longint'(pix_b), eb.v);
                check("b_out_row", row_b, eb.r);
                check("b_out_col", col_b, eb.c);
                check("b_frame_done", fd_b, eb.last);
            end
        end
    end

    function automatic logic [143:0] fill(input int v);
        logic [143:0] f;
        for (int i = 0; i < 9; i++) f[i*16 +: 16] = 16'(v);
        return f;
    endfunction

    task automatic push(input int sel, input longint v, input int idx, input int n);
        exp_t e;
        e.v = v;
        e.r = idx / n;
        e.c = idx % n;
        e.last = (idx == n * n - 1);
        if (sel != 0) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic send(input int sel, input int v, input bit gap);
        int n = 0;
        if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
        while (!(sel != 0 ? ready_b : ready_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 0, 1);
            return;
        end
        pixel_in = 16'(v);
        valid_in = 1;
        @(negedge clk);
        valid_in = 0;
    endtask

    task automatic rst(input int sel, input bit load, input logic [143:0] w, input int b,
                       output int lowcnt);
        bit lo0;
        valid_in = 0;
        weight = w;
        bias = 16'(b);
        weight_load = load;
        if (sel != 0) reset_b = 1;
        else reset_a = 1;
        repeat (2) @(negedge clk);
        check("ready_in_reset", sel != 0 ? ready_b : ready_a, 0);
        if (sel != 0) qb.delete();
        else qa.delete();
        if (sel != 0) reset_b = 0;
        else reset_a = 0;
        #1 lo0 = !(sel != 0 ? ready_b : ready_a);
        @(negedge clk);
        weight_load = 0;
        lowcnt = int'(lo0);
        while (!(sel != 0 ? ready_b : ready_a) && lowcnt < 20) begin
            lowcnt++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while ((sel != 0 ? qb.size() : qa.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", sel != 0 ? qb.size() : qa.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ident = fill(0);
        ident[4*16 +: 16] = 16'd1;
        @(negedge clk);
        // all-ones image and kernel with padding
        rst(0, 1, fill(1), 0, lc);
        check("a_ready_low_after_reset", lc, 7);
        for (int i = 0; i < 16; i++) push(0, ones_t[i], i, 4);
        for (int i = 0; i < 16; i++) send(0, 1, 0);
        drain(0);
        // identity kernel plus bias, with latency measurement
        rst(0, 1, ident, 5, lc);
        first_a = -1;
        for (int i = 0; i < 16; i++) push(0, i + 5, i, 4);
        for (int i = 0; i < 16; i++) begin
            send(0, i, 0);
            if (i == 5) hs5 = cyc;
        end
        drain(0);
        check("a_latency_edges", first_a - hs5, 2);
        // gapped frame followed by a back-to-back frame
        rst(0, 1, ident, 5, lc);
        for (int i = 0; i < 16; i++) push(0, 3 * i - 7 + 5, i, 4);
        for (int i = 0; i < 16; i++) push(0, 100 + i + 5, i, 4);
        for (int i = 0; i < 16; i++) send(0, 3 * i - 7, 1);
        for (int i = 0; i < 16; i++) send(0, 100 + i, 0);
        drain(0);
        // negative kernel without ReLU
        rst(0, 1, fill(-1), 0, lc);
        for (int i = 0; i < 16; i++) push(0, -3 * ones_t[i], i, 4);
        for (int i = 0; i < 16; i++) send(0, 3, 0);
        drain(0);
        // mid-frame reset
        rst(0, 1, fill(1), 0, lc);
        for (int i = 0; i < 16; i++) push(0, ones_t[i], i, 4);
        for (int i = 0; i < 8; i++) send(0, 1, 0);
        g = 0;
        while (!valid_a && g < 100) begin
            @(negedge clk);
            g++;
        end
        reset_a = 1;
        #1;
        check("a_rst_pixel_out", longint'(pix_a), 0);
        check("a_rst_valid_out", valid_a, 0);
        check("a_rst_row_col", {row_a, col_a}, 0);
        check("a_rst_frame_done", fd_a, 0);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_ready", ready_a, 0);
        qa.delete();
        // weights were cleared; loading while busy must be ignored until the frame ends
        rst(0, 0, fill(1), 0, lc);
        for (int i = 0; i < 16; i++) push(0, 0, i, 4);
        check("a_busy_mid_frame", busy_a, 1);
        weight_load = 1;
        for (int i = 0; i < 16; i++) send(0, 1, 0);
        g = 0;
        while (!fd_a && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("a_frame_done_seen", fd_a, 1);
        check("a_busy_at_frame_done", busy_a, 0);
        @(negedge clk);
        weight_load = 0;
        for (int i = 0; i < 16; i++) push(0, ones_t[i], i, 4);
        for (int i = 0; i < 16; i++) send(0, 1, 0);
        drain(0);
        // valid-conv instance with ReLU
        reset_a = 1;
        rst(1, 1, fill(1), 0, lc);
        check("b_ready_low_after_reset", lc, 0);
        b_active = 1;
        for (int i = 0; i < 4; i++) push(1, b_t[i], i, 2);
        for (int i = 0; i < 16; i++) send(1, i, 0);
        drain(1);
        b_active = 0;
        rst(1, 1, fill(-1), 0, lc);
        b_active = 1;
        for (int i = 0; i < 4; i++) push(1, 0, i, 2);
        for (int i = 0; i < 16; i++) send(1, 3, 0);
        drain(1);
        b_active = 0;
        check("b_ready_low_cycles", rb_low, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
